// File: rtl/ll_crc_check.sv
// Loopback CRC checker: snapshots TX CRCs at accepted EOPs into a small FIFO and
// compares them in order against RX CRC snapshots, with saturating counters and sticky errors.
module ll_crc_check #(
  parameter int DEPTH   = 4,
  parameter int CRC_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_en,
  input  logic             chk_clr,
  input  logic             DMALLTXEOPN,
  input  logic             DMALLTXSRCRDYN,
  input  logic             LLDMATXDSTRDYN,
  input  logic             LLDMARXEOPN,
  input  logic             LLDMARXSRCRDYN,
  input  logic             DMALLRXDSTRDYN,
  input  logic [31:0]      crc_tx,
  input  logic [31:0]      crc_rx,
  output logic [CNT_W-1:0] tx_frames,
  output logic [CNT_W-1:0] rx_frames,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [31:0]      last_exp,
  output logic [31:0]      last_got,
  output logic             err_mis,
  output logic             err_ovf,
  output logic             err_unf,
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [AW:0]      PTR_ONE = 1;

  logic               tx_ev, rx_ev;
  logic [CRC_LAT-1:0] tx_dly_q, tx_dly_d, rx_dly_q, rx_dly_d;
  logic [31:0]        mem_q [DEPTH];
  logic [AW:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, mis_cnt_q, mis_cnt_d;
  logic [31:0]        exp_q, exp_d, got_q, got_d, head;
  logic               err_mis_q, err_mis_d, err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
  logic               irq_q, irq_d;
  logic               empty, full, push_req, pop_req, push_ok, pop_ok, mis;

  assign tx_ev = chk_en & ~LLDMATXDSTRDYN & ~DMALLTXSRCRDYN & ~DMALLTXEOPN;
  assign rx_ev = chk_en & ~DMALLRXDSTRDYN & ~LLDMARXSRCRDYN & ~LLDMARXEOPN;

  // Delay EOP events so they line up with the monitor's CRC for that beat
  generate
    if (CRC_LAT == 1) begin : g_lat1
      assign tx_dly_d = tx_ev;
      assign rx_dly_d = rx_ev;
    end else begin : g_latn
      assign tx_dly_d = {tx_dly_q[CRC_LAT-2:0], tx_ev};
      assign rx_dly_d = {rx_dly_q[CRC_LAT-2:0], rx_ev};
    end
  endgenerate

  assign push_req = tx_dly_q[CRC_LAT-1];
  assign pop_req  = rx_dly_q[CRC_LAT-1];
  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head     = mem_q[rd_q[AW-1:0]];
  // Pop sees pre-push state; a pop frees the slot a concurrent push needs when full
  assign pop_ok   = pop_req & ~empty;
  assign push_ok  = push_req & (~full | pop_ok);
  assign mis      = pop_ok & (head != crc_rx);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + CNT_ONE;
    return v;
  endfunction

  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    exp_d     = exp_q;
    got_d     = got_q;
    if (push_ok) wr_d = wr_q + PTR_ONE;
    if (pop_ok)  rd_d = rd_q + PTR_ONE;
    if (mis) begin
      exp_d = head;
      got_d = crc_rx;
    end
    tx_cnt_d  = sat_inc(tx_cnt_q, push_ok);
    rx_cnt_d  = sat_inc(rx_cnt_q, pop_ok);
    mis_cnt_d = sat_inc(mis_cnt_q, mis);
    err_mis_d = err_mis_q | mis;
    err_ovf_d = err_ovf_q | (push_req & ~push_ok);
    err_unf_d = err_unf_q | (pop_req & empty);
    irq_d     = |({err_mis_d, err_ovf_d, err_unf_d} & ~{err_mis_q, err_ovf_q, err_unf_q});
  end

  always_ff @(posedge clk) begin
    if (!rst_n || chk_clr) begin
      tx_dly_q  <= '0;
      rx_dly_q  <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      mis_cnt_q <= '0;
      exp_q     <= '0;
      got_q     <= '0;
      err_mis_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      tx_dly_q  <= tx_dly_d;
      rx_dly_q  <= rx_dly_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      exp_q     <= exp_d;
      got_q     <= got_d;
      err_mis_q <= err_mis_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      irq_q     <= irq_d;
    end
  end

  // Snapshot storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (rst_n && !chk_clr && push_ok) mem_q[wr_q[AW-1:0]] <= crc_tx;
  end

  assign tx_frames = tx_cnt_q;
  assign rx_frames = rx_cnt_q;
  assign mis_cnt   = mis_cnt_q;
  assign last_exp  = exp_q;
  assign last_got  = got_q;
  assign err_mis   = err_mis_q;
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_ll_crc_check.sv
// Bench for ll_crc_check: a queue-based model predicts counters/flags per EOP step and a
// scoreboard compares them when the DUT's registers reflect that step.
module tb_ll_crc_check;
  localparam int DEPTH = 4, CRC_LAT = 2, CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0, chk_clr = 1'b0;
  logic DMALLTXEOPN = 1'b1, DMALLTXSRCRDYN = 1'b1, LLDMATXDSTRDYN = 1'b1;
  logic LLDMARXEOPN = 1'b1, LLDMARXSRCRDYN = 1'b1, DMALLRXDSTRDYN = 1'b1;
  logic [31:0] crc_tx = '0, crc_rx = '0;
  logic [CNT_W-1:0] tx_frames, rx_frames, mis_cnt;
  logic [31:0] last_exp, last_got;
  logic err_mis, err_ovf, err_unf, irq;
  logic [3:0] tx_frames_s, rx_frames_s, mis_cnt_s;
  logic [31:0] last_exp_s, last_got_s;
  logic err_mis_s, err_ovf_s, err_unf_s, irq_s;

  always #5 clk = ~clk;

  ll_crc_check #(.DEPTH(DEPTH), .CRC_LAT(CRC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .chk_clr(chk_clr),
    .DMALLTXEOPN(DMALLTXEOPN), .DMALLTXSRCRDYN(DMALLTXSRCRDYN), .LLDMATXDSTRDYN(LLDMATXDSTRDYN),
    .LLDMARXEOPN(LLDMARXEOPN), .LLDMARXSRCRDYN(LLDMARXSRCRDYN), .DMALLRXDSTRDYN(DMALLRXDSTRDYN),
    .crc_tx(crc_tx), .crc_rx(crc_rx),
    .tx_frames(tx_frames), .rx_frames(rx_frames), .mis_cnt(mis_cnt),
    .last_exp(last_exp), .last_got(last_got),
    .err_mis(err_mis), .err_ovf(err_ovf), .err_unf(err_unf), .irq(irq)
  );

  // Narrow-counter build sharing the same stimulus, used for saturation
  ll_crc_check #(.DEPTH(DEPTH), .CRC_LAT(CRC_LAT), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .chk_clr(chk_clr),
    .DMALLTXEOPN(DMALLTXEOPN), .DMALLTXSRCRDYN(DMALLTXSRCRDYN), .LLDMATXDSTRDYN(LLDMATXDSTRDYN),
    .LLDMARXEOPN(LLDMARXEOPN), .LLDMARXSRCRDYN(LLDMARXSRCRDYN), .DMALLRXDSTRDYN(DMALLRXDSTRDYN),
    .crc_tx(crc_tx), .crc_rx(crc_rx),
    .tx_frames(tx_frames_s), .rx_frames(rx_frames_s), .mis_cnt(mis_cnt_s),
    .last_exp(last_exp_s), .last_got(last_got_s),
    .err_mis(err_mis_s), .err_ovf(err_ovf_s), .err_unf(err_unf_s), .irq(irq_s)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    int          tx, rx, mis;
    logic [31:0] exp, got;
    logic [2:0]  flg;
  } rec_t;
  rec_t sb[$];

  logic [31:0] mq[$];
  int m_tx, m_rx, m_mis, m_irq = 0;
  logic [31:0] m_exp, m_got;
  logic m_fm, m_fo, m_fu;
  logic [31:0] tx_pipe [CRC_LAT];
  logic [31:0] rx_pipe [CRC_LAT];
  int edge_cnt = 0;
  int irq_seen = 0;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_tx = 0; m_rx = 0; m_mis = 0;
    m_exp = '0; m_got = '0;
    m_fm = 1'b0; m_fo = 1'b0; m_fu = 1'b0;
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin : sb_check
    rec_t r;
    if (irq === 1'b1) irq_seen++;
    while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      r = sb.pop_front();
      check($sformatf("sb@%0d.tx_frames", r.due), 32'(tx_frames), 32'(r.tx));
      check($sformatf("sb@%0d.rx_frames", r.due), 32'(rx_frames), 32'(r.rx));
      check($sformatf("sb@%0d.mis_cnt", r.due), 32'(mis_cnt), 32'(r.mis));
      check($sformatf("sb@%0d.last_exp", r.due), last_exp, r.exp);
      check($sformatf("sb@%0d.last_got", r.due), last_got, r.got);
      check($sformatf("sb@%0d.flags", r.due), 32'({err_mis, err_ovf, err_unf}), 32'(r.flg));
    end
  end

  // One clock cycle of stimulus; rdy args are {src_ok, dst_ok}
  task automatic step(input bit te, input bit [1:0] trdy, input logic [31:0] tv,
                      input bit re, input bit [1:0] rrdy, input logic [31:0] rv,
                      input bit en, input bit clr);
    bit tf, rf;
    logic [2:0] old;
    logic [31:0] h;
    rec_t r;
    @(negedge clk);
    chk_en = en; chk_clr = clr;
    DMALLTXEOPN = ~te; DMALLTXSRCRDYN = ~trdy[1]; LLDMATXDSTRDYN = ~trdy[0];
    LLDMARXEOPN = ~re; LLDMARXSRCRDYN = ~rrdy[1]; DMALLRXDSTRDYN = ~rrdy[0];
    // The monitor CRC for this beat appears CRC_LAT cycles later
    crc_tx = tx_pipe[CRC_LAT-1];
    crc_rx = rx_pipe[CRC_LAT-1];
    for (int i = CRC_LAT - 1; i > 0; i--) begin
      tx_pipe[i] = tx_pipe[i-1];
      rx_pipe[i] = rx_pipe[i-1];
    end
    tx_pipe[0] = tv;
    rx_pipe[0] = rv;
    if (clr) begin
      model_reset();
    end else begin
      tf = te && (trdy == 2'b11) && en;
      rf = re && (rrdy == 2'b11) && en;
      old = {m_fm, m_fo, m_fu};
      if (rf) begin
        if (mq.size() == 0) m_fu = 1'b1;
        else begin
          h = mq.pop_front();
          m_rx = sat16(m_rx + 1);
          if (h != rv) begin
            m_mis = sat16(m_mis + 1);
            m_exp = h; m_got = rv; m_fm = 1'b1;
          end
        end
      end
      if (tf) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(tv);
          m_tx = sat16(m_tx + 1);
        end else m_fo = 1'b1;
      end
      if (({m_fm, m_fo, m_fu} & ~old) != 3'b000) m_irq++;
      if (te || re) begin
        r.due = edge_cnt + 1 + CRC_LAT;
        r.tx = m_tx; r.rx = m_rx; r.mis = m_mis;
        r.exp = m_exp; r.got = m_got; r.flg = {m_fm, m_fo, m_fu};
        sb.push_back(r);
      end
    end
  endtask

  task automatic tx(input logic [31:0] v);
    step(1'b1, 2'b11, v, 1'b0, 2'b11, $urandom, 1'b1, 1'b0);
  endtask

  task automatic rx(input logic [31:0] v);
    step(1'b0, 2'b11, $urandom, 1'b1, 2'b11, v, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'b11, $urandom, 1'b0, 2'b11, $urandom, 1'b1, 1'b0);
  endtask

  task automatic clr_now();
    step(1'b0, 2'b11, $urandom, 1'b0, 2'b11, $urandom, 1'b1, 1'b1);
    idle(1);
  endtask

  task automatic expect_zero(input string tag);
    check({tag, ".tx_frames"}, 32'(tx_frames), 32'd0);
    check({tag, ".rx_frames"}, 32'(rx_frames), 32'd0);
    check({tag, ".mis_cnt"}, 32'(mis_cnt), 32'd0);
    check({tag, ".last_exp"}, last_exp, 32'd0);
    check({tag, ".last_got"}, last_got, 32'd0);
    check({tag, ".flags"}, 32'({err_mis, err_ovf, err_unf}), 32'd0);
    check({tag, ".irq"}, 32'(irq), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int irq0;
    for (int i = 0; i < CRC_LAT; i++) begin
      tx_pipe[i] = '0;
      rx_pipe[i] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    expect_zero("reset");
    check("reset.tx_frames_s", 32'(tx_frames_s), 32'd0);
    rst_n = 1'b1;

    // 1: three matching frames, TX then RX
    tx(32'hCAFE0001); tx(32'hCAFE0002); tx(32'hCAFE0003);
    idle(3);
    rx(32'hCAFE0001); rx(32'hCAFE0002); rx(32'hCAFE0003);
    idle(4);
    check("t1.tx_frames", 32'(tx_frames), 32'd3);
    check("t1.rx_frames", 32'(rx_frames), 32'd3);
    check("t1.mis_cnt", 32'(mis_cnt), 32'd0);
    check("t1.irq_pulses", 32'(irq_seen), 32'd0);

    // 2: mismatch on frame 2
    clr_now();
    irq0 = irq_seen;
    tx(32'h00001111); tx(32'h12345678); tx(32'h00003333);
    idle(2);
    rx(32'h00001111); rx(32'hDEADBEEF); rx(32'h00003333);
    idle(4);
    check("t2.mis_cnt", 32'(mis_cnt), 32'd1);
    check("t2.last_exp", last_exp, 32'h12345678);
    check("t2.last_got", last_got, 32'hDEADBEEF);
    check("t2.err_mis", 32'(err_mis), 32'd1);
    check("t2.irq_pulses", 32'(irq_seen - irq0), 32'd1);

    // 3: fill, full+pop+push, overflow, drain
    clr_now();
    tx(32'hA0); tx(32'hA1); tx(32'hA2); tx(32'hA3);
    idle(1);
    step(1'b1, 2'b11, 32'hA4, 1'b1, 2'b11, 32'hA0, 1'b1, 1'b0);
    idle(4);
    check("t3.full_pp.err_ovf", 32'(err_ovf), 32'd0);
    check("t3.full_pp.tx_frames", 32'(tx_frames), 32'd5);
    tx(32'hA5); tx(32'hA6);
    idle(4);
    check("t3.ovf.tx_frames", 32'(tx_frames), 32'd5);
    check("t3.ovf.err_ovf", 32'(err_ovf), 32'd1);
    rx(32'hA1); rx(32'hA2); rx(32'hA3); rx(32'hA4);
    idle(4);
    check("t3.drain.rx_frames", 32'(rx_frames), 32'd5);
    check("t3.drain.mis_cnt", 32'(mis_cnt), 32'd0);
    check("t3.drain.err_unf", 32'(err_unf), 32'd0);

    // 4: RX on empty FIFO with concurrent TX push
    clr_now();
    step(1'b1, 2'b11, 32'h55, 1'b1, 2'b11, 32'h55, 1'b1, 1'b0);
    idle(4);
    check("t4.err_unf", 32'(err_unf), 32'd1);
    check("t4.tx_frames", 32'(tx_frames), 32'd1);
    rx(32'h55);
    idle(4);
    check("t4.rx_frames", 32'(rx_frames), 32'd1);
    check("t4.err_mis", 32'(err_mis), 32'd0);

    // 5: ungranted/disabled EOPs ignored, then clear mid-frame
    clr_now();
    step(1'b1, 2'b10, 32'h77, 1'b0, 2'b11, 32'h0, 1'b1, 1'b0);
    step(1'b1, 2'b01, 32'h78, 1'b0, 2'b11, 32'h0, 1'b1, 1'b0);
    step(1'b1, 2'b11, 32'h79, 1'b1, 2'b11, 32'h79, 1'b0, 1'b0);
    step(1'b0, 2'b11, 32'h0, 1'b1, 2'b01, 32'h7A, 1'b1, 1'b0);
    idle(4);
    check("t5.ign.tx_frames", 32'(tx_frames), 32'd0);
    check("t5.ign.flags", 32'({err_mis, err_ovf, err_unf}), 32'd0);
    tx(32'h1); idle(1); rx(32'h2);
    idle(4);
    check("t5.pre.err_mis", 32'(err_mis), 32'd1);
    step(1'b0, 2'b11, $urandom, 1'b0, 2'b11, $urandom, 1'b1, 1'b1);
    idle(1);
    expect_zero("t5.clr");

    // 6: saturation on the narrow build
    clr_now();
    for (int i = 0; i < 20; i++) begin
      tx(32'h1000 + 32'(i));
      rx(32'h1000 + 32'(i));
    end
    idle(4);
    check("t6.tx_frames_s", 32'(tx_frames_s), 32'd15);
    check("t6.rx_frames_s", 32'(rx_frames_s), 32'd15);
    check("t6.tx_frames", 32'(tx_frames), 32'd20);
    tx(32'h2000); rx(32'h2000);
    idle(4);
    check("t6.hold.tx_frames_s", 32'(tx_frames_s), 32'd15);
    check("t6.hold.mis_cnt_s", 32'(mis_cnt_s), 32'd0);

    idle(5);
    check("sb_drain", 32'(sb.size()), 32'd0);
    check("irq_total", 32'(irq_seen), 32'(m_irq));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
